// File: rtl/sync_ring_dco.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ring_dco
//  Purpose  : Synchronous ring DCO. Half-period = DIV*(coarse+1) + fine clk
//             cycles. The control word is adopted only at rising boundaries,
//             so each output period is glitch-free. Provides clean start/stop,
//             a period strobe and optional fractional dithering.
//  Options  : DCO_DITHER_EN - when defined, a FRAC_W-bit accumulator adds the
//             frac field once per period and a carry stretches that period's
//             LOW half by one cycle. When undefined the frac bits are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_ring_dco #(
    parameter int COARSE_W = 6,
    parameter int FINE_W   = 2,
    parameter int FRAC_W   = 4,
    parameter int DIV      = 4,
    localparam int CODE_W  = COARSE_W + FINE_W + FRAC_W,
    localparam int CNT_W   = $clog2(DIV * (2 ** COARSE_W) + (2 ** FINE_W)) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CODE_W-1:0] code,
    output logic              out_clk,
    output logic              period_start,
    output logic              running
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CODE_W-1:0] code_q;
    logic              out_clk_q;
    logic              period_start_q;
    logic              running_q;

    // Half-period length in clk cycles for a given coarse/fine pair.
    function automatic logic [CNT_W-1:0] half_of(
        input logic [COARSE_W-1:0] coarse,
        input logic [FINE_W-1:0]   fine
    );
        return CNT_W'(DIV) * (CNT_W'(coarse) + CNT_W'(1)) + CNT_W'(fine);
    endfunction

    logic [CNT_W-1:0] half_in;   // from the live code input (used when latching)
    logic [CNT_W-1:0] half_lat;  // from the latched code (used for the LOW half)
    logic             lo_ext;    // one extra LOW cycle from a dither carry
    logic [CNT_W-1:0] lo_ext_cnt;
    logic             cnt_zero;
    logic             rise_evt;  // edge at which a new period begins
    logic             stop_evt;  // edge at which the oscillator parks in IDLE

    assign half_in    = half_of(code[CODE_W-1 -: COARSE_W], code[FRAC_W +: FINE_W]);
    assign half_lat   = half_of(code_q[CODE_W-1 -: COARSE_W], code_q[FRAC_W +: FINE_W]);
    assign lo_ext_cnt = {{(CNT_W-1){1'b0}}, lo_ext};
    assign cnt_zero   = (cnt_q == '0);
    assign rise_evt   = enable && ((state_q == ST_IDLE) || ((state_q == ST_LOW) && cnt_zero));
    assign stop_evt   = !enable && (state_q == ST_LOW) && cnt_zero;

`ifdef DCO_DITHER_EN
    logic [FRAC_W-1:0] acc_q;
    logic              carry_q;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, code[FRAC_W-1:0]};
    assign lo_ext  = carry_q;

    // Accumulate the fraction once per period; the carry stretches the coming LOW half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (rise_evt) begin
            acc_q   <= acc_sum[FRAC_W-1:0];
            carry_q <= acc_sum[FRAC_W];
        end else if (stop_evt) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end
    end
`else
    assign lo_ext = 1'b0;
`endif

    // Frac bits of the latched word are informational only (dither reads the live input).
    logic unused_frac;
    assign unused_frac = ^code_q[FRAC_W-1:0];

    // Oscillator FSM: times each half with a down-counter, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            code_q         <= '0;
            out_clk_q      <= 1'b0;
            period_start_q <= 1'b0;
            running_q      <= 1'b0;
        end else begin
            period_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q        <= ST_HIGH;
                        code_q         <= code;
                        cnt_q          <= half_in - CNT_W'(1);
                        out_clk_q      <= 1'b1;
                        period_start_q <= 1'b1;
                        running_q      <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_zero) begin
                        state_q   <= ST_LOW;
                        cnt_q     <= half_lat - CNT_W'(1) + lo_ext_cnt;
                        out_clk_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (enable) begin
                        // Rising boundary: the only point where a new code is adopted.
                        state_q        <= ST_HIGH;
                        code_q         <= code;
                        cnt_q          <= half_in - CNT_W'(1);
                        out_clk_q      <= 1'b1;
                        period_start_q <= 1'b1;
                    end else begin
                        // Stop exactly where the next rise would have been.
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    out_clk_q <= 1'b0;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_clk      = out_clk_q;
    assign period_start = period_start_q;
    assign running      = running_q;

endmodule
`default_nettype wire

// File: doc/sync_ring_dco.md
# sync_ring_dco

Parametrised synchronous ring DCO: the next generation of the ring oscillator, with coarse delay-cell selection and fine buffer trim, fully clocked from `clk`. Output half-period = coarse stages × cells-per-stage cycles + fine cycles, set by a control word. The word is adopted only at period boundaries, which gives the glitch-free compensation the old mux-plus-compensation path attempted. Adds clean start/stop, a period strobe and optional fractional dithering. Sits between the AD-PLL loop filter (code source) and the feedback divider/TDC (out_clk consumer).

## Interface
- `COARSE_W`, 6: coarse code width; selects 1..2^COARSE_W delay stages.
- `FINE_W`, 2: fine code width; adds 0..2^FINE_W-1 single-cycle buffers.
- `FRAC_W`, 4: fractional code width (used only with dither compiled in).
- `DIV`, 4: clk cycles per coarse stage; must be ≥ 2^FINE_W (monotonic tuning).
- Derived: `CODE_W` = COARSE_W+FINE_W+FRAC_W; `CNT_W` = clog2(DIV·2^COARSE_W + 2^FINE_W) + 1.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: run request, sampled each clk.
- `code` input CODE_W: {coarse, fine, frac}, coarse MSBs, frac LSBs.
- `out_clk` output 1: DCO output, registered.
- `period_start` output 1: one-cycle pulse on the cycle out_clk rises.
- `running` output 1: high while state ≠ IDLE.

## Operation
- Half-period H = DIV·(coarse+1) + fine cycles. Unsigned arithmetic. Range DIV..DIV·2^COARSE_W+2^FINE_W-1. Defaults: 4..259.
- States:
  - IDLE: out_clk=0.
  - HIGH: out_clk=1.
  - LOW: out_clk=0.
- Down-counter `cnt` (CNT_W bits) times each half.
- IDLE→HIGH on an edge with enable=1:
  - latch code into `code_q`;
  - cnt←H-1, out_clk←1, period_start←1, running←1.
- HIGH: decrement cnt. At cnt=0 → LOW, cnt←H-1 (plus dither extension), out_clk←0.
- LOW: decrement cnt. At cnt=0:
  - if enable=1: → HIGH, relatch code, reload cnt, out_clk←1, period_start←1;
  - else: → IDLE, running←0.
- Code is sampled only at a rising boundary. Changes at any other time are ignored until the next period_start. HIGH and LOW of one period use the same code_q.
- Deasserting enable never truncates a period. The current HIGH and LOW always complete. Enable re-asserted before LOW ends means no stop.
- Reset values: out_clk=0, period_start=0, running=0, state=IDLE, cnt=0, code_q=0, dither accumulator=0.
- Reset asserted mid-operation forces all of these immediately, asynchronously.

## Timing
- Start latency: enable sampled high at edge k → out_clk=1 and period_start=1 after edge k.
- HIGH lasts exactly H cycles. LOW lasts H cycles, or H+1 with a dither carry. Period = 2H or 2H+1.
- Back-to-back periods have no gap cycle. period_start fires every 2H(+1) cycles.
- Stop: running falls on the same edge out_clk would otherwise have risen. out_clk stays 0 thereafter.
- Minimum legal H = DIV ≥ 2 (guarantees cnt reload precedes the boundary compare).

## Configuration
- `DCO_DITHER_EN` defined:
  - FRAC_W-bit accumulator `acc`. At each period_start, acc←acc+frac.
  - A carry out of the add extends that period's LOW half by one cycle.
  - acc clears on entry to IDLE.
  - Average period = 2H + frac/2^FRAC_W.
- `DCO_DITHER_EN` undefined:
  - frac bits ignored; no accumulator.
  - Period is exactly 2H.

## Test plan
Defaults throughout: DIV=4, FINE_W=2, COARSE_W=6, FRAC_W=4.
- coarse=0, fine=0, frac=0, enable=1 → out_clk 4 high / 4 low. Period 8. period_start every 8 cycles.
- coarse=3, fine=1 → H=17. 17 high / 17 low. Period 34.
- Run coarse=0, then change code to coarse=3 on cycle 2 of HIGH → current period stays 8. Next period is 34, starting at the following period_start.
- enable→0 in mid-HIGH (H=4) → remaining HIGH plus 4 LOW cycles complete. Then running=0, out_clk held 0, no further period_start.
- With `DCO_DITHER_EN`, H=4, frac=4 → periods 8,8,8,9 repeating. Average 8.25 over 16 periods. Without the macro → all periods 8.
- rst_n low mid-LOW → out_clk, period_start, running = 0 immediately. After release with enable=1, first period_start arrives one edge later with full-length HIGH.
